// File: rtl/shared_mult_arbiter.sv
// -----------------------------------------------------------------------------
// shared_mult_arbiter
//
// Purpose:
//   Lets NREQ requesters share one multiplier. Each cycle a round-robin arbiter
//   picks at most one valid request. Its operands are multiplied as unsigned
//   values and the low OUT_WIDTH bits of the product go down a LATENCY-deep
//   register pipeline. Each result comes back tagged with the ID of the
//   requester that issued it, and results leave in acceptance order.
//
// Ports:
//   clk        in   1              rising-edge clock
//   reset_n    in   1              asynchronous active-low reset
//   req_valid  in   NREQ           per-requester request valid
//   req_ready  out  NREQ           per-requester accept (one-hot or zero)
//   req_left   in   NREQ*IN_WIDTH  left operands, requester i at [i*IN_WIDTH +: IN_WIDTH]
//   req_right  in   NREQ*IN_WIDTH  right operands, same packing
//   rsp_valid  out  1              result valid
//   rsp_ready  in   1              result consumer ready
//   rsp_id     out  IDW            requester that owns rsp_data
//   rsp_data   out  OUT_WIDTH      product, low OUT_WIDTH bits
//   stat_issued out 32             (SHARED_MULT_ARB_STATS_EN only) accepted requests
//   stat_stall  out 32             (SHARED_MULT_ARB_STATS_EN only) cycles with rsp_valid & !rsp_ready
//
// Configuration macro: SHARED_MULT_ARB_STATS_EN adds the two statistics
// counters and their ports. When it is undefined they are absent.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A producer holding valid may change or drop it before the
// transfer; no state changes until a transfer occurs. req_ready depends
// combinationally on req_valid and rsp_ready. rsp_valid and its payload stay
// stable until rsp_ready is seen.
// -----------------------------------------------------------------------------
module shared_mult_arbiter #(
    parameter int NREQ      = 4,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 32,
    parameter int LATENCY   = 2,
    parameter int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*IN_WIDTH-1:0] req_left,
    input  logic [NREQ*IN_WIDTH-1:0] req_right,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [OUT_WIDTH-1:0]     rsp_data
`ifdef SHARED_MULT_ARB_STATS_EN
    ,
    output logic [31:0]              stat_issued,
    output logic [31:0]              stat_stall
`endif
);

    // Round-robin pointer: the last requester granted. The scan starts one past it.
    logic [IDW-1:0]       ptr;
    logic                 advance;
    logic                 found;
    logic [IDW-1:0]       winner;
    logic                 accept;
    logic [IN_WIDTH-1:0]  sel_left;
    logic [IN_WIDTH-1:0]  sel_right;
    logic [OUT_WIDTH-1:0] product;

    logic                 st_vld  [LATENCY];
    logic [IDW-1:0]       st_id   [LATENCY];
    logic [OUT_WIDTH-1:0] st_data [LATENCY];

    // A full pipe may still move when the consumer takes the head this cycle.
    // That allows pass-through.
    assign advance = !rsp_valid || rsp_ready;
    assign accept  = advance && found;

    // Scan from ptr+1, wrapping. A requester that drops valid before it is
    // granted never moves ptr, so it does not lose its turn.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept && (winner == IDW'(i));
        end
    end

    always_comb begin
        sel_left  = '0;
        sel_right = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner == IDW'(i)) begin
                sel_left  = req_left[i*IN_WIDTH +: IN_WIDTH];
                sel_right = req_right[i*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    // The multiply is done at OUT_WIDTH bits. When OUT_WIDTH is smaller than
    // 2*IN_WIDTH, the low bits of a product depend only on the low bits of the
    // operands. When OUT_WIDTH is larger, the zero-extended operands give the
    // full product. Both cases give the same result as a full-width multiply
    // that is then truncated or zero-extended.
    assign product = OUT_WIDTH'(sel_left) * OUT_WIDTH'(sel_right);

    // All stages move together on advance. On a stall every stage holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= IDW'(NREQ - 1);
            for (int s = 0; s < LATENCY; s++) begin
                st_vld[s]  <= 1'b0;
                st_id[s]   <= '0;
                st_data[s] <= '0;
            end
        end else if (advance) begin
            st_vld[0] <= accept;
            if (accept) begin
                st_id[0]   <= winner;
                st_data[0] <= product;
                ptr        <= winner;
            end
            for (int s = 1; s < LATENCY; s++) begin
                st_vld[s]  <= st_vld[s-1];
                st_id[s]   <= st_id[s-1];
                st_data[s] <= st_data[s-1];
            end
        end
    end

    assign rsp_valid = st_vld[LATENCY-1];
    assign rsp_id    = st_id[LATENCY-1];
    assign rsp_data  = st_data[LATENCY-1];

`ifdef SHARED_MULT_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (accept) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (rsp_valid && !rsp_ready) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_shared_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_mult_arbiter
//
// Bench for shared_mult_arbiter. The main instance uses NREQ=4, 32x32->32 and
// LATENCY=2. A second instance uses 8x8->8 to exercise truncation. A negedge
// monitor keeps its own round-robin pointer to predict req_ready. On each
// accept it pushes the expected {id, product} to exp_q, and on each response
// handshake it pops and compares. Directed sequences cover latency, grant
// rotation, stalls with pass-through, truncation and reset mid-operation.
// Random traffic follows.
// -----------------------------------------------------------------------------
module tb_shared_mult_arbiter;

    localparam int NREQ = 4;
    localparam int IW   = 32;
    localparam int OW   = 32;
    localparam int LAT  = 2;
    localparam int IDW  = 2;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main DUT signals ----------------
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*IW-1:0] req_left  = '0;
    logic [NREQ*IW-1:0] req_right = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic [IDW-1:0]     rsp_id;
    logic [OW-1:0]      rsp_data;

    // ---------------- 8-bit DUT signals ----------------
    logic [NREQ-1:0]    r8_valid = '0;
    logic [NREQ-1:0]    r8_ready;
    logic [NREQ*8-1:0]  r8_left  = '0;
    logic [NREQ*8-1:0]  r8_right = '0;
    logic               rsp8_valid;
    logic               rsp8_ready = 1'b1;
    logic [IDW-1:0]     rsp8_id;
    logic [7:0]         rsp8_data;

`ifdef SHARED_MULT_ARB_STATS_EN
    logic [31:0] stat_issued, stat_stall;
    logic [31:0] stat8_issued, stat8_stall;
`endif

    shared_mult_arbiter #(
        .NREQ(NREQ), .IN_WIDTH(IW), .OUT_WIDTH(OW), .LATENCY(LAT)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_left  (req_left),
        .req_right (req_right),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
`ifdef SHARED_MULT_ARB_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall)
`endif
    );

    shared_mult_arbiter #(
        .NREQ(NREQ), .IN_WIDTH(8), .OUT_WIDTH(8), .LATENCY(LAT)
    ) u_dut8 (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (r8_valid),
        .req_ready (r8_ready),
        .req_left  (r8_left),
        .req_right (r8_right),
        .rsp_valid (rsp8_valid),
        .rsp_ready (rsp8_ready),
        .rsp_id    (rsp8_id),
        .rsp_data  (rsp8_data)
`ifdef SHARED_MULT_ARB_STATS_EN
        ,
        .stat_issued (stat8_issued),
        .stat_stall  (stat8_stall)
`endif
    );

    // ---------------- scoreboard state ----------------
    int                 checks    = 0;
    int                 failures  = 0;
    logic [IDW+OW-1:0]  exp_q[$];
    int                 grant_log[$];
    logic [IDW-1:0]     mptr      = IDW'(NREQ - 1);
    int                 acc_count = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] model_mul(input logic [IW-1:0] l, input logic [IW-1:0] r);
        logic [2*IW-1:0] p;
        p = {{IW{1'b0}}, l} * {{IW{1'b0}}, r};
        return p[OW-1:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [IW-1:0] l, input logic [IW-1:0] r);
        req_valid[i]          = v;
        req_left[i*IW +: IW]  = l;
        req_right[i*IW +: IW] = r;
    endtask

    task automatic randomize_operands();
        for (int i = 0; i < NREQ; i++) begin
            req_left[i*IW +: IW]  = $urandom();
            req_right[i*IW +: IW] = $urandom();
        end
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        r8_valid  = '0;
        rsp_ready = 1'b1;
        repeat (2) step();
        reset_n = 1'b1;
    endtask

    task automatic drain();
        int  n;
        logic done;
        n = 0;
        rsp_ready = 1'b1;
        req_valid = '0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 50) begin
            step();
            n++;
        end
        done = (exp_q.size() == 0) && !rsp_valid;
        check("drain_done", done, 1'b1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : mon
        logic               adv;
        logic               fnd;
        int                 g;
        int                 idx;
        logic [NREQ-1:0]    exp_rdy;
        logic [IDW+OW-1:0]  e;
        if (!reset_n) begin
            mptr      = IDW'(NREQ - 1);
            acc_count = 0;
            exp_q.delete();
        end else begin
            adv = !rsp_valid || rsp_ready;
            fnd = 1'b0;
            g   = 0;
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(mptr) + k) % NREQ;
                if (!fnd && req_valid[idx]) begin
                    fnd = 1'b1;
                    g   = idx;
                end
            end
            exp_rdy = '0;
            if (adv && fnd) exp_rdy[g] = 1'b1;
            check("req_ready", req_ready, exp_rdy);
            if (adv && fnd) begin
                exp_q.push_back({IDW'(g), model_mul(req_left[g*IW +: IW], req_right[g*IW +: IW])});
                mptr = IDW'(g);
                acc_count++;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) grant_log.push_back(i);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_id", rsp_id, e[IDW+OW-1:OW]);
                    check("rsp_data", rsp_data, e[OW-1:0]);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [IW-1:0] l0, r0;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_id", rsp_id, '0);
        check("reset_rsp_data", rsp_data, '0);
        check("reset_req_ready", req_ready, '0);
        step();
        reset_n = 1'b1;

        // Test 1: single request from requester 2, LATENCY check
        set_req(2, 1'b1, 32'd7, 32'd6);
        @(negedge clk);
        check("t1_req_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        @(negedge clk);
        check("t1_no_early_rsp", rsp_valid, 1'b0);
        step();
        @(negedge clk);
        check("t1_rsp_valid", rsp_valid, 1'b1);
        check("t1_rsp_id", rsp_id, 2'd2);
        check("t1_rsp_data", rsp_data, 32'd42);
        step();
        drain();

        // Test 2: all requesters valid for 8 cycles, rotation 0,1,2,3,...
        apply_reset();
        grant_log.delete();
        randomize_operands();
        req_valid = '1;
        repeat (8) step();
        req_valid = '0;
        drain();
        check("t2_grant_count", grant_log.size(), 8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
            check("t2_grant_order", grant_log[k], k % NREQ);
        end

        // Test 3 (and stats): fill the pipe, stall 3 cycles, release with pass-through
        apply_reset();
        randomize_operands();
        l0 = req_left[0 +: IW];
        r0 = req_right[0 +: IW];
        rsp_ready = 1'b0;
        req_valid = '1;
        step();
        step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_stall_ready", req_ready, '0);
            check("t3_stall_valid", rsp_valid, 1'b1);
            check("t3_stall_id", rsp_id, 2'd0);
            check("t3_stall_data", rsp_data, model_mul(l0, r0));
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t3_pass_through", req_ready, 4'b0100);
        step();
        drain();
`ifdef SHARED_MULT_ARB_STATS_EN
        check("t6_stat_stall", stat_stall, 32'd3);
        check("t6_stat_issued", stat_issued, 32'(acc_count));
        check("t6_issued_three", acc_count, 3);
`endif

        // Test 4: 8x8->8 truncation on the second instance
        apply_reset();
        r8_valid        = 4'b0010;
        r8_left[15:8]   = 8'hFF;
        r8_right[15:8]  = 8'hFF;
        @(negedge clk);
        check("t4_ready", r8_ready, 4'b0010);
        step();
        r8_valid = '0;
        step();
        @(negedge clk);
        check("t4_rsp_valid", rsp8_valid, 1'b1);
        check("t4_rsp_id", rsp8_id, 2'd1);
        check("t4_rsp_data", rsp8_data, 8'h01);
        step();

        // Test 5: reset with two results in flight
        apply_reset();
        randomize_operands();
        req_valid = '1;
        step();
        step();
        reset_n   = 1'b0;
        req_valid = '0;
        repeat (2) step();
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_no_rsp_after_reset", rsp_valid, 1'b0);
            step();
        end
        req_valid = '1;
        @(negedge clk);
        check("t5_first_grant", req_ready, 4'b0001);
        step();
        drain();

        // Random traffic: valid patterns that change freely, consumer back-pressure
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            req_valid = NREQ'($urandom_range(0, 15));
            randomize_operands();
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
